// File: rtl/neuron_acc.sv
// neuron_acc: sequential float accumulator for one neuron.
// Sums a stream of {sign, exponent, fraction} operands using one adder that
// is shared over four cycles per operand (IDLE -> ALIGN -> ADD -> NORM).
// The finished sum is presented to the activation stage through a
// valid/ready handshake.
// Optional feature macro: NEURON_BIAS_EN. When defined, the accumulator
// starts each vector from bias_in instead of +0.
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   operand valid
//   in_ready   block can accept an operand
//   in_data    operand {s, e, f}
//   in_last    marks the final operand of the vector
//   bias_in    neuron bias (NEURON_BIAS_EN only)
//   out_valid  sum valid
//   out_ready  downstream accepts the sum
//   out_data   accumulated sum
module neuron_acc #(
  parameter int unsigned E_BIT = 5,
  parameter int unsigned F_BIT = 10,
  localparam int unsigned D_LEN = 1 + E_BIT + F_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D_LEN-1:0] in_data,
  input  logic             in_last,
`ifdef NEURON_BIAS_EN
  input  logic [D_LEN-1:0] bias_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_LEN-1:0] out_data
);

  // Mantissa width with hidden bit and carry bit
  localparam int unsigned M_W = F_BIT + 2;
  // Signed-safe exponent width for the normalisation arithmetic
  localparam int unsigned X_W = E_BIT + 2;
  localparam int unsigned L_W = $clog2(M_W);
  localparam logic [E_BIT-1:0] E_SAT = E_BIT'((1 << E_BIT) - 2);
  localparam logic [X_W-1:0]   E_OVF = X_W'((1 << E_BIT) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [D_LEN-1:0] op_q, op_d;
  logic             last_q, last_d;
  logic [D_LEN-1:0] acc_q, acc_d;
  logic [M_W-1:0]   ma_q, ma_d;
  logic [M_W-1:0]   mb_q, mb_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [E_BIT-1:0] exp_q, exp_d;
  logic [M_W-1:0]   sum_q, sum_d;
  logic             rs_q, rs_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [D_LEN-1:0] out_data_q, out_data_d;
`ifdef NEURON_BIAS_EN
  // Bias still has to be loaded after reset release
  logic             bias_pend_q, bias_pend_d;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Leading-zero count of the mantissa below the carry bit
  function automatic logic [L_W-1:0] lzc(input logic [M_W-2:0] m);
    lzc = L_W'(M_W - 1);
    for (int i = 0; i < int'(M_W - 1); i++) begin
      if (m[i]) lzc = L_W'(int'(M_W) - 2 - i);
    end
  endfunction

  // Alignment: exponent 0 means zero; smaller operand shifted right
  logic [E_BIT-1:0] a_e, b_e, big_e, diff;
  logic [M_W-1:0]   a_m, b_m, al_a, al_b;

  always_comb begin
    a_e   = acc_q[F_BIT +: E_BIT];
    b_e   = op_q[F_BIT +: E_BIT];
    a_m   = (a_e == '0) ? '0 : {2'b01, acc_q[F_BIT-1:0]};
    b_m   = (b_e == '0) ? '0 : {2'b01, op_q[F_BIT-1:0]};
    big_e = a_e;
    diff  = '0;
    al_a  = a_m;
    al_b  = b_m;
    if (a_e >= b_e) begin
      big_e = a_e;
      diff  = a_e - b_e;
      al_b  = (32'(diff) >= M_W) ? '0 : (b_m >> diff);
    end else begin
      big_e = b_e;
      diff  = b_e - a_e;
      al_a  = (32'(diff) >= M_W) ? '0 : (a_m >> diff);
    end
  end

  // Signed-magnitude add; result sign follows the larger magnitude
  logic [M_W-1:0] add_sum;
  logic           add_sign;

  always_comb begin
    add_sum  = '0;
    add_sign = sa_q;
    if (sa_q == sb_q) begin
      add_sum  = ma_q + mb_q;
      add_sign = sa_q;
    end else if (ma_q >= mb_q) begin
      add_sum  = ma_q - mb_q;
      add_sign = sa_q;
    end else begin
      add_sum  = mb_q - ma_q;
      add_sign = sb_q;
    end
  end

  // Normalise, truncate, saturate on overflow, flush to +0 on underflow
  logic [L_W-1:0]   lz;
  logic [X_W-1:0]   ne;
  logic [F_BIT-1:0] nf;
  logic             unf, ovf;
  logic [D_LEN-1:0] norm_res;

  always_comb begin
    lz = lzc(sum_q[M_W-2:0]);
    if (sum_q[M_W-1]) begin
      nf = sum_q[F_BIT:1];
      ne = X_W'(exp_q) + X_W'(1);
    end else begin
      nf = F_BIT'(sum_q << lz);
      ne = X_W'(exp_q) - X_W'(lz);
    end
    unf = ne[X_W-1] || (ne == '0);
    ovf = !ne[X_W-1] && (ne >= E_OVF);
    if (sum_q == '0)  norm_res = '0;
    else if (ovf)     norm_res = {rs_q, E_SAT, {F_BIT{1'b1}}};
    else if (unf)     norm_res = '0;
    else              norm_res = {rs_q, ne[E_BIT-1:0], nf};
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    last_d      = last_q;
    acc_d       = acc_q;
    ma_d        = ma_q;
    mb_d        = mb_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    exp_d       = exp_q;
    sum_d       = sum_q;
    rs_d        = rs_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef NEURON_BIAS_EN
    bias_pend_d = bias_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          op_d    = in_data;
          last_d  = in_last;
          state_d = S_ALIGN;
`ifdef NEURON_BIAS_EN
          if (bias_pend_q) begin
            acc_d       = bias_in;
            bias_pend_d = 1'b0;
          end
`endif
        end
      end
      S_ALIGN: begin
        ma_d    = al_a;
        mb_d    = al_b;
        sa_d    = acc_q[D_LEN-1];
        sb_d    = op_q[D_LEN-1];
        exp_d   = big_e;
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d   = add_sum;
        rs_d    = add_sign;
        state_d = S_NORM;
      end
      S_NORM: begin
        acc_d = norm_res;
        if (last_q) begin
          out_data_d  = norm_res;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef NEURON_BIAS_EN
          acc_d       = bias_in;
`else
          acc_d       = '0;
`endif
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      exp_q       <= '0;
      sum_q       <= '0;
      rs_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef NEURON_BIAS_EN
      bias_pend_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      last_q      <= last_d;
      acc_q       <= acc_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      exp_q       <= exp_d;
      sum_q       <= sum_d;
      rs_q        <= rs_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef NEURON_BIAS_EN
      bias_pend_q <= bias_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_acc.sv
// Directed bench for neuron_acc (E_BIT=5, F_BIT=10): expected sums are queued
// when the last operand is accepted and compared when the sum is presented.
module tb_neuron_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [15:0] bias_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  neuron_acc #(.E_BIT(5), .F_BIT(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
`ifdef NEURON_BIAS_EN
    .bias_in  (bias_in),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Offer one operand, check the busy window and the output latency
  task automatic send(input logic [15:0] d, input logic last, input logic [15:0] expv);
    int n;
    @(negedge clk);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 16'(n < 100), 16'd1);
    @(posedge clk);
    if (last) sb.push_back(expv);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("in_ready_busy", 16'(in_ready), 16'd0);
      if (last) chk("out_valid_early", 16'(out_valid), 16'd0);
    end
    @(negedge clk);
    if (last) chk("latency_out_valid", 16'(out_valid), 16'd1);
    else      chk("in_ready_back", 16'(in_ready), 16'd1);
  endtask

  // Wait for a sum, compare against the scoreboard, then accept it
  task automatic recv(input string tag);
    int n;
    logic [15:0] e;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait"}, 16'(n < 100), 16'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    chk(tag, out_data, e);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, 16'(out_valid), 16'd0);
    chk({tag, "_ready"}, 16'(in_ready), 16'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    bias_in   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_data", out_data, 16'h0000);
    rst = 1'b0;

    // Single operand
    send(16'h3C00, 1'b1, 16'h3C00);
    recv("single_one");

    // 1 + 1 + 0.5
    send(16'h3C00, 1'b0, 16'h0);
    send(16'h3C00, 1'b0, 16'h0);
    send(16'h3800, 1'b1, 16'h4100);
    recv("sum_2p5");

    // Exact cancellation gives +0
    send(16'h3C00, 1'b0, 16'h0);
    send(16'hBC00, 1'b1, 16'h0000);
    recv("cancel");

    // Small operand drops out in alignment
    send(16'h6400, 1'b0, 16'h0);
    send(16'h1000, 1'b1, 16'h6400);
    recv("align_drop");

    // Mixed signs with left normalisation; sign of larger magnitude
    send(16'h3C00, 1'b0, 16'h0);
    send(16'hB800, 1'b1, 16'h3800);
    recv("sub_norm_pos");
    send(16'h3800, 1'b0, 16'h0);
    send(16'hBC00, 1'b1, 16'hB800);
    recv("sub_norm_neg");

    // Underflow flushes to +0
    send(16'h0600, 1'b0, 16'h0);
    send(16'h8400, 1'b1, 16'h0000);
    recv("underflow");

    // Saturation, both signs
    send(16'h7BFF, 1'b0, 16'h0);
    send(16'h7BFF, 1'b1, 16'h7BFF);
    recv("sat_pos");
    send(16'hFBFF, 1'b0, 16'h0);
    send(16'hFBFF, 1'b1, 16'hFBFF);
    recv("sat_neg");

    // out_ready with no pending sum is ignored
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_ready", 16'(out_valid), 16'd0);

    // Backpressure: sum held stable
    send(16'h3C00, 1'b1, 16'h3C00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 16'(out_valid), 16'd1);
      chk("hold_data", out_data, 16'h3C00);
      chk("hold_in_ready", 16'(in_ready), 16'd0);
    end
    recv("hold_release");
    send(16'h4000, 1'b1, 16'h4000);
    recv("after_clear");

    // Reset in the middle of a vector
    send(16'h3C00, 1'b0, 16'h0);
    @(negedge clk);
    in_data  = 16'h3C00;
    in_last  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_busy", 16'(in_ready), 16'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
    chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_out_data", out_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    send(16'h3C00, 1'b1, 16'h3C00);
    recv("after_rst");

`ifdef NEURON_BIAS_EN
    // Bias loaded after reset: -1 + 2 = 1
    bias_in = 16'hBC00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(16'h4000, 1'b1, 16'h3C00);
    bias_in = 16'h0000;
    recv("bias_sum");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
